uio_bus_arbiter: RTL and testbench
==================================

UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum beats per transaction; len_i width SHALL be clog2(MAX_LEN).
REQ-002 Parameter TURN_CYC, default 1: idle bus cycles inserted on a direction change, with uio_oe=0.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 ena  in  1  design-selected; low blocks new grants and forces uio_oe=0.
REQ-006 req_i  in  2  per-requester transaction request, level.
REQ-007 wr_i  in  2  per-requester direction: 1 = drive pins, 0 = sample pins.
REQ-008 len0_i, len1_i  in  clog2(MAX_LEN) each  beats minus one.
REQ-009 wdata0_i, wdata1_i  in  8 each  per-beat write data.
REQ-010 gnt_o  out  2  one-hot grant, held for TURN and XFER.
REQ-011 beat_o  out  1  high on every XFER cycle.
REQ-012 rdata_o  out  8  equals uio_in on read beats, 0 otherwise.
REQ-013 done_o  out  2  one-cycle pulse to the owner on its last beat.
REQ-014 uio_in in 8; uio_out out 8; uio_oe out 8  shared bidirectional pins.

Function
REQ-015 The FSM SHALL have states IDLE, TURN and XFER.
REQ-016 IDLE with ena=1 and req_i!=0: latch winner, its wr and len; next state TURN if winner wr != dir_q and TURN_CYC>0, else XFER.
REQ-017 Arbitration SHALL be round-robin: after a transaction ends or aborts, the other requester gets priority; after reset req 0 has priority.
REQ-018 A lone requester SHALL win regardless of priority.
REQ-019 TURN SHALL last exactly TURN_CYC cycles with uio_oe=8'h00, then go to XFER; dir_q SHALL take the winner wr on TURN entry.
REQ-020 XFER SHALL last exactly latched len+1 cycles, counted by a beat counter.
REQ-021 Write beat: uio_out = owner wdata (combinational, no register), uio_oe = 8'hFF.
REQ-022 Read beat: uio_oe = 8'h00, rdata_o = uio_in combinationally.
REQ-023 Last beat: done_o[owner]=1 in that cycle, then IDLE.
REQ-024 Minimum gap between transactions: one IDLE cycle.
REQ-025 The length latched at grant SHALL be used; later len changes SHALL be ignored.
REQ-026 req_i deasserted mid-transaction SHALL be ignored; the transaction completes.
REQ-027 ena=0 in TURN/XFER SHALL force uio_oe=0 and beat_o=0 that cycle, go to IDLE next cycle with no done pulse, and advance priority.
REQ-028 Outside XFER write beats: uio_out=8'h00 and uio_oe=8'h00.
REQ-029 Grant-to-first-beat latency: 1 cycle with no turnaround, 1+TURN_CYC cycles with turnaround.

Reset
REQ-030 With rst=1 at a clock edge, all state SHALL clear: state=IDLE, gnt_o=0, done_o=0, beat_o=0, uio_oe=0, uio_out=0, rdata_o=0, dir_q=0 (read), priority=req 0, beat counter=0.
REQ-031 rst mid-transaction SHALL abort it at the next edge without a done pulse.
REQ-032 rst SHALL take precedence over ena and req_i.

Structure
REQ-033 Package uio_arb_pkg SHALL hold the state enum, DIR_RD/DIR_WR constants and the default MAX_LEN/TURN_CYC.
REQ-034 Sub-module rr_arb2 SHALL implement the combinational 2-way round-robin pick from (req, priority), returning one-hot.
REQ-035 All other logic SHALL reside in uio_bus_arbiter.

Verification
REQ-036 Reset, then req_i=01, wr=1, len0=2, wdata0=8'hA5 -> 3 write beats, uio_oe=FF, uio_out=A5, done_o=01 on beat 3; first beat 2 cycles after req (one TURN, since dir_q=0).
REQ-037 req_i=11 held, both read, len=0 -> grants alternate 01,10,01 with exactly one IDLE between them; uio_oe stays 00.
REQ-038 Write by req 0 then read by req 1 with TURN_CYC=1 -> exactly one cycle with gnt_o=10 and uio_oe=00 before its beat; rdata_o tracks uio_in=8'h3C.
REQ-039 ena dropped on beat 2 of a 4-beat write -> uio_oe=00 that cycle, IDLE next, no done, req 1 gets priority.
REQ-040 rst pulsed mid-XFER -> all outputs 0 next cycle; a subsequent req_i=11 grants req 0 first.

Source files
------------

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the UIO bus arbiter slice.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    localparam int DEF_MAX_LEN  = 8;
    localparam int DEF_TURN_CYC = 1;

    // Requester index to one-hot grant vector.
    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester always wins,
// on contention the requester named by prio wins. Result is one-hot (or 0).
module rr_arb2
    import uio_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // Pick the winner from the request vector and current priority holder.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = onehot2(prio);
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Two-requester arbiter for a shared 8-bit bidirectional pin bus.
// A transaction is a burst of len+1 beats in one direction; a direction
// change inserts TURN_CYC idle cycles with the pins released.
//
// state | meaning
// IDLE  | bus free, pick a winner when enabled
// TURN  | pins released while the bus changes direction
// XFER  | one beat per cycle for the granted owner
module uio_bus_arbiter #(
    parameter int MAX_LEN  = uio_arb_pkg::DEF_MAX_LEN,
    parameter int TURN_CYC = uio_arb_pkg::DEF_TURN_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [1:0]                 req_i,
    input  logic [1:0]                 wr_i,
    input  logic [$clog2(MAX_LEN)-1:0] len0_i,
    input  logic [$clog2(MAX_LEN)-1:0] len1_i,
    input  logic [7:0]                 wdata0_i,
    input  logic [7:0]                 wdata1_i,
    output logic [1:0]                 gnt_o,
    output logic                       beat_o,
    output logic [7:0]                 rdata_o,
    output logic [1:0]                 done_o,
    input  logic [7:0]                 uio_in,
    output logic [7:0]                 uio_out,
    output logic [7:0]                 uio_oe
);
    import uio_arb_pkg::*;

    localparam int LW = $clog2(MAX_LEN);
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    // Turnaround counter reload: counts down to zero, so TURN_CYC-1.
    localparam logic [TW-1:0] TURN_LAST = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            wr_q, wr_d;
    logic [LW-1:0]   len_q, len_d;
    logic            dir_q, dir_d;
    logic            prio_q, prio_d;
    logic [LW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]   turn_cnt_q, turn_cnt_d;

    logic [1:0]      pick;
    logic            pick_idx;
    logic            sel_wr;
    logic [LW-1:0]   sel_len;
    logic            last_beat;
    logic            wr_beat;
    logic            rd_beat;

    rr_arb2 u_rr_arb2 (
        .req  (req_i),
        .prio (prio_q),
        .gnt  (pick)
    );

    assign pick_idx  = pick[1];
    assign sel_wr    = pick_idx ? wr_i[1] : wr_i[0];
    assign sel_len   = pick_idx ? len1_i : len0_i;
    assign last_beat = (beat_cnt_q == len_q);

    // Register all FSM and transaction context; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            wr_q       <= DIR_RD;
            len_q      <= '0;
            dir_q      <= DIR_RD;
            prio_q     <= 1'b0;
            beat_cnt_q <= '0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            len_q      <= len_d;
            dir_q      <= dir_d;
            prio_q     <= prio_d;
            beat_cnt_q <= beat_cnt_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    // Next-state logic: grant in IDLE, count turnaround and beats, abort on ena=0.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        len_d      = len_q;
        dir_d      = dir_q;
        prio_d     = prio_q;
        beat_cnt_d = beat_cnt_q;
        turn_cnt_d = turn_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (ena && (pick != 2'b00)) begin
                    owner_d    = pick_idx;
                    wr_d       = sel_wr;
                    len_d      = sel_len;
                    dir_d      = sel_wr;
                    beat_cnt_d = '0;
                    if ((sel_wr != dir_q) && (TURN_CYC > 0)) begin
                        state_d    = ST_TURN;
                        turn_cnt_d = TURN_LAST;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end

            ST_TURN: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                    prio_d  = ~owner_q;
                end else if (turn_cnt_q == '0) begin
                    state_d = ST_XFER;
                end else begin
                    turn_cnt_d = turn_cnt_q - TW'(1);
                end
            end

            ST_XFER: begin
                if (!ena) begin
                    state_d = ST_IDLE;
                    prio_d  = ~owner_q;
                end else if (last_beat) begin
                    state_d = ST_IDLE;
                    prio_d  = ~owner_q;
                end else begin
                    beat_cnt_d = beat_cnt_q + LW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus-side outputs are purely combinational from state so reset clears them at once.
    always_comb begin
        gnt_o   = 2'b00;
        beat_o  = 1'b0;
        done_o  = 2'b00;
        rdata_o = 8'h00;
        uio_out = 8'h00;
        uio_oe  = 8'h00;
        wr_beat = 1'b0;
        rd_beat = 1'b0;

        if (state_q != ST_IDLE) begin
            gnt_o = onehot2(owner_q);
        end

        if ((state_q == ST_XFER) && ena) begin
            beat_o  = 1'b1;
            wr_beat = (wr_q == DIR_WR);
            rd_beat = (wr_q == DIR_RD);
            if (last_beat) begin
                done_o = onehot2(owner_q);
            end
        end

        if (wr_beat) begin
            uio_oe  = 8'hFF;
            uio_out = owner_q ? wdata1_i : wdata0_i;
        end

        if (rd_beat) begin
            rdata_o = uio_in;
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter with default parameters (MAX_LEN=8, TURN_CYC=1).
// Scenario tasks push the expected beats to a scoreboard and check cycle
// timing inline; a negedge monitor pops and compares every beat.
module tb_uio_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [1:0] wr_i = 2'b00;
    logic [2:0] len0_i = 3'd0;
    logic [2:0] len1_i = 3'd0;
    logic [7:0] wdata0_i = 8'h00;
    logic [7:0] wdata1_i = 8'h00;
    logic [1:0] gnt_o;
    logic       beat_o;
    logic [7:0] rdata_o;
    logic [1:0] done_o;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    typedef struct {
        logic [1:0] gnt;
        logic [7:0] oe;
        logic [7:0] out;
        logic [7:0] rdata;
        logic [1:0] done;
    } beat_t;

    beat_t sb[$];
    beat_t exp_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uio_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .req_i    (req_i),
        .wr_i     (wr_i),
        .len0_i   (len0_i),
        .len1_i   (len1_i),
        .wdata0_i (wdata0_i),
        .wdata1_i (wdata1_i),
        .gnt_o    (gnt_o),
        .beat_o   (beat_o),
        .rdata_o  (rdata_o),
        .done_o   (done_o),
        .uio_in   (uio_in),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe)
    );

    // Scoreboard monitor: every beat must match the next expected beat;
    // done must never pulse outside a beat.
    always @(negedge clk) begin
        if (beat_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_beat t=%0t gnt=%b out=%h", $time, gnt_o, uio_out);
            end else begin
                exp_b = sb.pop_front();
                if ({gnt_o, uio_oe, uio_out, rdata_o, done_o} !==
                    {exp_b.gnt, exp_b.oe, exp_b.out, exp_b.rdata, exp_b.done}) begin
                    errors++;
                    $display("FAIL sb_beat t=%0t got gnt=%b oe=%h out=%h rdata=%h done=%b want gnt=%b oe=%h out=%h rdata=%h done=%b",
                             $time, gnt_o, uio_oe, uio_out, rdata_o, done_o,
                             exp_b.gnt, exp_b.oe, exp_b.out, exp_b.rdata, exp_b.done);
                end
            end
        end else begin
            checks++;
            if (done_o !== 2'b00) begin
                errors++;
                $display("FAIL done_outside_beat t=%0t got %b want 00", $time, done_o);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_beat(input logic [1:0] g, input logic [7:0] oe, input logic [7:0] o,
                             input logic [7:0] rd, input logic [1:0] dn);
        beat_t b;
        b.gnt = g; b.oe = oe; b.out = o; b.rdata = rd; b.done = dn;
        sb.push_back(b);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_i = 2'b00;
        ena = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; req_i = 2'b11; wr_i = 2'b11; uio_in = 8'h77;
        wdata0_i = 8'hFF; wdata1_i = 8'hFF;
        step();
        step();
        sample();
        checks++;
        if ({gnt_o, beat_o, done_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got gnt=%b beat=%b done=%b want 00/0/00", gnt_o, beat_o, done_o);
        end
        checks++;
        if ({uio_oe, uio_out, rdata_o} !== 24'h0) begin
            errors++;
            $display("FAIL reset_bus got oe=%h out=%h rdata=%h want 00/00/00", uio_oe, uio_out, rdata_o);
        end
        step();
        rst = 1'b0; ena = 1'b0;
        sample();
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL ena_low_no_grant got %b want 00", gnt_o);
        end
        step();
        sample();
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL ena_low_still_idle got %b want 00", gnt_o);
        end
        req_i = 2'b00; wr_i = 2'b00;
    endtask

    task automatic test_write();
        apply_reset();
        ena = 1'b1; req_i = 2'b01; wr_i = 2'b01; len0_i = 3'd2; len1_i = 3'd5;
        wdata0_i = 8'hA5; wdata1_i = 8'hEE; uio_in = 8'h00;
        push_beat(2'b01, 8'hFF, 8'hA5, 8'h00, 2'b00);
        push_beat(2'b01, 8'hFF, 8'h5A, 8'h00, 2'b00);
        push_beat(2'b01, 8'hFF, 8'h5A, 8'h00, 2'b01);
        sample();
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL wr_c0_idle got gnt=%b want 00", gnt_o);
        end
        step();
        sample();
        checks++;
        if ({gnt_o, uio_oe, beat_o} !== {2'b01, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL wr_turn got gnt=%b oe=%h beat=%b want 01/00/0", gnt_o, uio_oe, beat_o);
        end
        step();
        req_i = 2'b00; len0_i = 3'd7;
        sample();
        checks++;
        if (beat_o !== 1'b1) begin
            errors++;
            $display("FAIL wr_first_beat_latency got beat=%b want 1", beat_o);
        end
        step();
        wdata0_i = 8'h5A;
        sample();
        step();
        sample();
        checks++;
        if (done_o !== 2'b01) begin
            errors++;
            $display("FAIL wr_done_beat3 got %b want 01", done_o);
        end
        step();
        sample();
        checks++;
        if ({gnt_o, beat_o} !== 3'b000) begin
            errors++;
            $display("FAIL wr_end_idle got gnt=%b beat=%b want 00/0", gnt_o, beat_o);
        end
    endtask

    task automatic test_rr_reads();
        logic [1:0] exp_g [7];
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
        apply_reset();
        ena = 1'b1; wr_i = 2'b00; len0_i = 3'd0; len1_i = 3'd0; uio_in = 8'h5A;
        req_i = 2'b11;
        push_beat(2'b01, 8'h00, 8'h00, 8'h5A, 2'b01);
        push_beat(2'b10, 8'h00, 8'h00, 8'h5A, 2'b10);
        push_beat(2'b01, 8'h00, 8'h00, 8'h5A, 2'b01);
        for (int i = 0; i < 7; i++) begin
            if (i != 0) step();
            if (i == 5) req_i = 2'b00;
            sample();
            checks++;
            if ({gnt_o, uio_oe} !== {exp_g[i], 8'h00}) begin
                errors++;
                $display("FAIL rr_cycle%0d got gnt=%b oe=%h want gnt=%b oe=00", i, gnt_o, uio_oe, exp_g[i]);
            end
        end
    endtask

    task automatic test_wr_then_rd();
        apply_reset();
        ena = 1'b1; wr_i = 2'b01; len0_i = 3'd0; len1_i = 3'd0;
        wdata0_i = 8'h11; wdata1_i = 8'hEE; uio_in = 8'h3C; req_i = 2'b01;
        push_beat(2'b01, 8'hFF, 8'h11, 8'h00, 2'b01);
        push_beat(2'b10, 8'h00, 8'h00, 8'h3C, 2'b10);
        sample();
        step();
        sample();
        step();
        req_i = 2'b10;
        sample();
        step();
        sample();
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL wrrd_gap_idle got gnt=%b want 00", gnt_o);
        end
        step();
        sample();
        checks++;
        if ({gnt_o, uio_oe, beat_o} !== {2'b10, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL wrrd_turn got gnt=%b oe=%h beat=%b want 10/00/0", gnt_o, uio_oe, beat_o);
        end
        step();
        req_i = 2'b00;
        sample();
        checks++;
        if ({gnt_o, beat_o} !== {2'b10, 1'b1}) begin
            errors++;
            $display("FAIL wrrd_read_beat got gnt=%b beat=%b want 10/1", gnt_o, beat_o);
        end
        #1;
        uio_in = 8'hC3;
        #1;
        checks++;
        if (rdata_o !== 8'hC3) begin
            errors++;
            $display("FAIL wrrd_rdata_comb got %h want c3", rdata_o);
        end
        step();
        sample();
        checks++;
        if ({gnt_o, rdata_o} !== {2'b00, 8'h00}) begin
            errors++;
            $display("FAIL wrrd_end got gnt=%b rdata=%h want 00/00", gnt_o, rdata_o);
        end
    endtask

    task automatic test_ena_abort();
        apply_reset();
        ena = 1'b1; wr_i = 2'b01; len0_i = 3'd3; len1_i = 3'd0;
        wdata0_i = 8'h5E; wdata1_i = 8'hEE; uio_in = 8'h81; req_i = 2'b01;
        push_beat(2'b01, 8'hFF, 8'h5E, 8'h00, 2'b00);
        sample();
        step();
        sample();
        step();
        req_i = 2'b00;
        sample();
        step();
        ena = 1'b0;
        sample();
        checks++;
        if ({uio_oe, uio_out, beat_o, done_o} !== {8'h00, 8'h00, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL abort_cycle got oe=%h out=%h beat=%b done=%b want 00/00/0/00",
                     uio_oe, uio_out, beat_o, done_o);
        end
        step();
        ena = 1'b1; req_i = 2'b11; wr_i = 2'b00;
        push_beat(2'b10, 8'h00, 8'h00, 8'h81, 2'b10);
        sample();
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle got gnt=%b want 00", gnt_o);
        end
        step();
        req_i = 2'b00;
        sample();
        checks++;
        if ({gnt_o, beat_o} !== {2'b10, 1'b0}) begin
            errors++;
            $display("FAIL abort_prio_turn got gnt=%b beat=%b want 10/0", gnt_o, beat_o);
        end
        step();
        sample();
        checks++;
        if ({gnt_o, beat_o} !== {2'b10, 1'b1}) begin
            errors++;
            $display("FAIL abort_prio_beat got gnt=%b beat=%b want 10/1", gnt_o, beat_o);
        end
        step();
        sample();
    endtask

    task automatic test_rst_mid();
        apply_reset();
        ena = 1'b1; wr_i = 2'b01; len0_i = 3'd3; len1_i = 3'd0;
        wdata0_i = 8'hC7; wdata1_i = 8'hEE; uio_in = 8'h99; req_i = 2'b01;
        push_beat(2'b01, 8'hFF, 8'hC7, 8'h00, 2'b00);
        sample();
        step();
        sample();
        step();
        rst = 1'b1;
        sample();
        step();
        rst = 1'b0; req_i = 2'b11; wr_i = 2'b00; len0_i = 3'd0;
        push_beat(2'b01, 8'h00, 8'h00, 8'h99, 2'b01);
        sample();
        checks++;
        if ({gnt_o, beat_o, done_o, uio_oe, uio_out, rdata_o} !== 29'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs got gnt=%b beat=%b done=%b oe=%h out=%h rdata=%h want all 0",
                     gnt_o, beat_o, done_o, uio_oe, uio_out, rdata_o);
        end
        step();
        req_i = 2'b00;
        sample();
        checks++;
        if ({gnt_o, beat_o} !== {2'b01, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_prio0 got gnt=%b beat=%b want 01/1", gnt_o, beat_o);
        end
        step();
        sample();
        checks++;
        if (gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_end got gnt=%b want 00", gnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_rr_reads();
        test_wr_then_rd();
        test_ena_abort();
        test_rst_mid();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
